// File: rtl/cv32e40p_tmr_scrub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_tmr_scrub_ctrl_if
// Description : Resync write-back handshake between the TMR scrub controller
//               (master) and the triplicated register block (slave).
//                 resync_req_o  - write-back request (master -> slave)
//                 resync_lane_o - target replica 0..2 (master -> slave)
//                 resync_data_o - voted value to write (master -> slave)
//                 resync_ack_i  - replica accepted the write (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40p_tmr_scrub_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             resync_req_o;
    logic [1:0]       resync_lane_o;
    logic [WIDTH-1:0] resync_data_o;
    logic             resync_ack_i;

    modport master (
        output resync_req_o,
        output resync_lane_o,
        output resync_data_o,
        input  resync_ack_i
    );

    modport slave (
        input  resync_req_o,
        input  resync_lane_o,
        input  resync_data_o,
        output resync_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_tmr_scrub_ctrl
// Description : Fault monitor / resynchronisation controller for a
//               triplicated register block. Votes the three replica words,
//               detects a single diverging replica and writes the voted value
//               back through the resync handshake; escalates to a sticky
//               fatal flag on multi-lane divergence or a lane that keeps
//               failing after PERSIST_MAX write-back attempts.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               check_en_i          - enables detection while idle
//               clear_i             - clears counters/flags, forces idle
//               res1_i..res3_i      - replica 0..2 state words
//               voted_o             - combinational bitwise majority
//               resync              - handshake interface (master modport)
//               fault_o / fatal_o   - sticky fault / unrecoverable flags
//               err_cnt_o           - packed per-lane counters, lane 0 LSBs
// Config      : CV32E40P_TMR_SCRUB_CNT_EN - when defined, per-lane saturating
//               error counters are built; otherwise err_cnt_o is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_scrub_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 8,
    parameter int PERSIST_MAX = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  check_en_i,
    input  wire logic                  clear_i,
    input  wire logic [WIDTH-1:0]      res1_i,
    input  wire logic [WIDTH-1:0]      res2_i,
    input  wire logic [WIDTH-1:0]      res3_i,
    output logic      [WIDTH-1:0]      voted_o,
    cv32e40p_tmr_scrub_ctrl_if.master  resync,
    output logic                       fault_o,
    output logic                       fatal_o,
    output logic      [3*CNT_W-1:0]    err_cnt_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESYNC = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] FATAL  = 2'd3;

    localparam logic [3:0] c_persist_max = 4'(PERSIST_MAX);

    logic [1:0]       r_state;
    logic [1:0]       r_lane;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_persist;
    logic             r_fault;
    logic             r_fatal;

    logic [WIDTH-1:0] w_voted;
    logic [2:0]       w_div;
    logic             w_multi;
    logic             w_single;
    logic [1:0]       w_lane;
    logic [3:0]       w_persist_nxt;
    logic             w_persist_hit;
    logic             w_same_lane;

    // Bitwise majority of the three replicas.
    assign w_voted = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);

    assign w_div[0] = (res1_i != w_voted);
    assign w_div[1] = (res2_i != w_voted);
    assign w_div[2] = (res3_i != w_voted);

    // All three lanes can diverge at once on different bit positions.
    assign w_multi  = (w_div[0] & w_div[1]) | (w_div[0] & w_div[2]) |
                      (w_div[1] & w_div[2]);
    assign w_single = (|w_div) & ~w_multi;

    // Lane index is only meaningful when w_single is set.
    assign w_lane = w_div[1] ? 2'd1 : (w_div[2] ? 2'd2 : 2'd0);

    assign w_persist_nxt = r_persist + 4'd1;
    assign w_persist_hit = (w_persist_nxt >= c_persist_max);
    assign w_same_lane   = w_single && (w_lane == r_lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lane    <= 2'd0;
            r_data    <= '0;
            r_persist <= 4'd0;
            r_fault   <= 1'b0;
            r_fatal   <= 1'b0;
        end else if (clear_i) begin
            // Wins over detection and over an ack arriving this cycle.
            r_state   <= IDLE;
            r_persist <= 4'd0;
            r_fault   <= 1'b0;
            r_fatal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (check_en_i && w_single) begin
                        r_lane    <= w_lane;
                        r_data    <= w_voted;
                        r_fault   <= 1'b1;
                        r_persist <= 4'd0;
                        r_state   <= RESYNC;
                    end else if (check_en_i && w_multi) begin
                        r_fault <= 1'b1;
                        r_fatal <= 1'b1;
                        r_state <= FATAL;
                    end
                end
                RESYNC: begin
                    if (resync.resync_ack_i) begin
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_div == 3'b000) begin
                        r_persist <= 4'd0;
                        r_state   <= IDLE;
                    end else if (w_same_lane) begin
                        r_persist <= w_persist_nxt;
                        if (w_persist_hit) begin
                            r_fatal <= 1'b1;
                            r_state <= FATAL;
                        end else begin
                            r_data  <= w_voted;
                            r_state <= RESYNC;
                        end
                    end else begin
                        r_fatal <= 1'b1;
                        r_state <= FATAL;
                    end
                end
                default: begin
                    r_state <= FATAL;
                end
            endcase
        end
    end

    assign voted_o              = w_voted;
    assign resync.resync_req_o  = (r_state == RESYNC);
    assign resync.resync_lane_o = r_lane;
    assign resync.resync_data_o = r_data;
    assign fault_o              = r_fault;
    assign fatal_o              = r_fatal;

`ifdef CV32E40P_TMR_SCRUB_CNT_EN
    // A lane's count advances once per write-back request issued to it: the
    // initial detection and every retry. The attempt that escalates to fatal
    // issues no request and is not counted.
    logic w_inc;

    assign w_inc = !clear_i &&
                   (((r_state == IDLE) && check_en_i && w_single) ||
                    ((r_state == SETTLE) && w_same_lane && !w_persist_hit));

    for (genvar k = 0; k < 3; k++) begin : g_lane_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (clear_i) begin
                r_cnt <= '0;
            end else if (w_inc && (w_lane == 2'(k)) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign err_cnt_o[k*CNT_W +: CNT_W] = r_cnt;
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_tmr_scrub_ctrl
// Description : Self-checking bench for cv32e40p_tmr_scrub_ctrl (CNT_W=2,
//               PERSIST_MAX=3). A vector table exercises the voter; directed
//               sequences cover the handshake, retries, fatal and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_tmr_scrub_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
    localparam int PMAX  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             check_en_i;
    logic             clear_i;
    logic [WIDTH-1:0] res1_i, res2_i, res3_i;
    logic [WIDTH-1:0] voted_o;
    logic             fault_o, fatal_o;
    logic [3*CNT_W-1:0] err_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_req = 0;

    cv32e40p_tmr_scrub_ctrl_if #(.WIDTH(WIDTH)) u_if ();

    cv32e40p_tmr_scrub_ctrl #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .PERSIST_MAX(PMAX)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .check_en_i(check_en_i),
        .clear_i   (clear_i),
        .res1_i    (res1_i),
        .res2_i    (res2_i),
        .res3_i    (res3_i),
        .voted_o   (voted_o),
        .resync    (u_if),
        .fault_o   (fault_o),
        .fatal_o   (fatal_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [WIDTH-1:0] a, b, c;
        logic [WIDTH-1:0] exp_voted;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int l0, input int l1, input int l2);
`ifdef CV32E40P_TMR_SCRUB_CNT_EN
        logic [3*CNT_W-1:0] v;
        v = {CNT_W'(l2), CNT_W'(l1), CNT_W'(l0)};
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (u_if.resync_req_o === 1'b1) n_req++;
    endtask

    vec_t vt [6];

    initial begin
        vt[0] = '{32'h0000_00A5, 32'h0000_00A4, 32'h0000_00A5, 32'h0000_00A5};
        vt[1] = '{32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 32'h0000_0000};
        vt[2] = '{32'hFFFF_0000, 32'h00FF_FF00, 32'h0F0F_0F0F, 32'h0FFF_0F00};
        vt[3] = '{32'h1234_5678, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678};
        vt[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst = 1'b1; check_en_i = 1'b0; clear_i = 1'b0; u_if.resync_ack_i = 1'b0;
        res1_i = '0; res2_i = '0; res3_i = '0;
        tick(); tick();
        rst = 1'b0;
        n_req = 0;
        chk("reset_req",   32'(u_if.resync_req_o),  0);
        chk("reset_lane",  32'(u_if.resync_lane_o), 0);
        chk("reset_data",  u_if.resync_data_o,      0);
        chk("reset_fault", 32'(fault_o),            0);
        chk("reset_fatal", 32'(fatal_o),            0);
        chk("reset_cnt",   32'(err_cnt_o),          0);

        // Voter table with detection disabled: no state change expected.
        for (int i = 0; i < 6; i++) begin
            res1_i = vt[i].a; res2_i = vt[i].b; res3_i = vt[i].c;
            #1;
            chk($sformatf("vote[%0d]", i), voted_o, vt[i].exp_voted);
            tick();
            chk($sformatf("vote_idle_req[%0d]", i), 32'(u_if.resync_req_o), 0);
        end
        chk("vote_no_fault", 32'(fault_o), 0);

        // Ack outside RESYNC is ignored.
        res1_i = 32'hA5; res2_i = 32'hA5; res3_i = 32'hA5;
        check_en_i = 1'b1; u_if.resync_ack_i = 1'b1;
        tick();
        chk("stray_ack_req", 32'(u_if.resync_req_o), 0);
        u_if.resync_ack_i = 1'b0;

        // Single fault on lane 1, immediate ack.
        res2_i = 32'hA4;
        tick();
        chk("s1_req",   32'(u_if.resync_req_o),  1);
        chk("s1_lane",  32'(u_if.resync_lane_o), 1);
        chk("s1_data",  u_if.resync_data_o,      32'hA5);
        chk("s1_fault", 32'(fault_o),            1);
        chk("s1_cnt",   32'(err_cnt_o),          ecnt(0, 1, 0));
        u_if.resync_ack_i = 1'b1;
        tick();
        chk("s1_settle_req", 32'(u_if.resync_req_o), 0);
        u_if.resync_ack_i = 1'b0;
        res2_i = 32'hA5;
        tick();
        chk("s1_idle_req", 32'(u_if.resync_req_o), 0);
        tick();
        chk("s1_idle_req2", 32'(u_if.resync_req_o), 0);
        chk("s1_fatal",     32'(fatal_o),           0);

        // Delayed ack: request held stable while the voted value moves.
        res2_i = 32'hA4;
        tick();
        for (int i = 0; i < 5; i++) begin
            res3_i = (i % 2 == 0) ? 32'h0 : 32'hA5;
            if (i == 4) res3_i = 32'hA5;
            tick();
            chk($sformatf("s2_req[%0d]", i),  32'(u_if.resync_req_o),  1);
            chk($sformatf("s2_lane[%0d]", i), 32'(u_if.resync_lane_o), 1);
            chk($sformatf("s2_data[%0d]", i), u_if.resync_data_o,      32'hA5);
        end
        u_if.resync_ack_i = 1'b1;
        tick();
        chk("s2_settle_req", 32'(u_if.resync_req_o), 0);
        u_if.resync_ack_i = 1'b0;
        res2_i = 32'hA5;
        tick();
        chk("s2_idle_req", 32'(u_if.resync_req_o), 0);
        tick();
        chk("s2_idle_req2", 32'(u_if.resync_req_o), 0);
        chk("s2_cnt",       32'(err_cnt_o),         ecnt(0, 2, 0));

        // Persistent fault on lane 2.
        n_req = 0;
        res3_i = 32'hA4;
        tick();
        chk("p_lane", 32'(u_if.resync_lane_o), 2);
        for (int r = 1; r <= 3; r++) begin
            u_if.resync_ack_i = 1'b1;
            tick();
            chk($sformatf("p_settle_req[%0d]", r), 32'(u_if.resync_req_o), 0);
            u_if.resync_ack_i = 1'b0;
            tick();
            if (r < 3) begin
                chk($sformatf("p_retry_req[%0d]", r), 32'(u_if.resync_req_o), 1);
                chk($sformatf("p_retry_data[%0d]", r), u_if.resync_data_o, 32'hA5);
            end else begin
                chk("p_fatal",     32'(fatal_o),           1);
                chk("p_fatal_req", 32'(u_if.resync_req_o), 0);
            end
        end
        chk("p_num_req", 32'(n_req),      3);
        chk("p_cnt",     32'(err_cnt_o),  ecnt(0, 2, 3));
        u_if.resync_ack_i = 1'b1;
        res3_i = 32'hA5;
        tick(); tick();
        chk("p_absorb_fatal", 32'(fatal_o),           1);
        chk("p_absorb_req",   32'(u_if.resync_req_o), 0);
        u_if.resync_ack_i = 1'b0;

        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr1_fatal", 32'(fatal_o),   0);
        chk("clr1_fault", 32'(fault_o),   0);
        chk("clr1_cnt",   32'(err_cnt_o), 0);

        // Multi fault.
        n_req = 0;
        res1_i = 32'hF0; res2_i = 32'h0F; res3_i = 32'h00;
        #1;
        chk("m_voted", voted_o, 32'h00);
        tick();
        chk("m_fatal", 32'(fatal_o), 1);
        chk("m_fault", 32'(fault_o), 1);
        chk("m_req",   32'(u_if.resync_req_o), 0);
        tick();
        chk("m_num_req", 32'(n_req), 0);
        chk("m_cnt",     32'(err_cnt_o), 0);

        // Clear in the same cycle as a detection discards it.
        res1_i = 32'h11; res2_i = 32'h10; res3_i = 32'h10;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr2_req",   32'(u_if.resync_req_o), 0);
        chk("clr2_fault", 32'(fault_o),           0);
        chk("clr2_fatal", 32'(fatal_o),           0);

        // Five corrected lane-0 faults saturate the 2-bit counter.
        for (int i = 1; i <= 5; i++) begin
            res1_i = 32'h11;
            tick();
            chk($sformatf("sat_req[%0d]", i), 32'(u_if.resync_req_o),  1);
            chk($sformatf("sat_lane[%0d]", i), 32'(u_if.resync_lane_o), 0);
            u_if.resync_ack_i = 1'b1;
            tick();
            u_if.resync_ack_i = 1'b0;
            res1_i = 32'h10;
            tick();
            chk($sformatf("sat_cnt[%0d]", i), 32'(err_cnt_o), ecnt((i > 3) ? 3 : i, 0, 0));
        end

        // Clear during RESYNC with a simultaneous ack drops the request.
        res1_i = 32'h11;
        tick();
        chk("cr_req_before", 32'(u_if.resync_req_o), 1);
        check_en_i = 1'b0;
        clear_i = 1'b1; u_if.resync_ack_i = 1'b1;
        tick();
        clear_i = 1'b0; u_if.resync_ack_i = 1'b0;
        chk("cr_req",   32'(u_if.resync_req_o), 0);
        chk("cr_fault", 32'(fault_o),           0);
        chk("cr_fatal", 32'(fatal_o),           0);
        chk("cr_cnt",   32'(err_cnt_o),         0);
        tick();
        chk("cr_stay_idle", 32'(u_if.resync_req_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
